// File: rtl/neopix_rx.sv
// neopix_rx: WS2812 single-wire receiver; decodes pulse widths into 24-bit pixels and flags the latch gap.
// Define NEOPIX_RX_FWD_EN to regenerate the stream on DOUT after consuming the first pixel of each frame.
module neopix_rx #(
   parameter int THRESH_CYC   = 10,
   parameter int MIN_HIGH_CYC = 2,
   parameter int MAX_HIGH_CYC = 32,
   parameter int RESET_CYC    = 800
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        DIN,
   output logic [23:0] PIX_DATA,
   output logic        PIX_VALID,
   output logic [15:0] PIX_INDEX,
   output logic        FRAME_END,
   output logic        ERR,
   output logic        DOUT
);
   localparam int LW = $clog2(RESET_CYC + 1);
   localparam int HW = $clog2(MAX_HIGH_CYC + 1);
   typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;
   state_t state, state_n;
   logic s1, din_s, d1, d2, rise, fall, bit_val;
   logic [LW-1:0] lcnt, lcnt_n;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [23:0] shift, shift_n, pix_data_n;
   logic [4:0] bit_cnt, bit_cnt_n;
   logic [15:0] pix_cnt, pix_cnt_n, pix_index_n;
   logic pix_valid_n, frame_end_n, err_n;
   // FSM runs on d1 so every strobe lands three edges after the DIN sample that caused it
   assign rise = d1 & ~d2;
   assign fall = ~d1 & d2;
   assign bit_val = hcnt >= HW'(THRESH_CYC);
   always_comb begin
      state_n = state;
      lcnt_n = lcnt;
      hcnt_n = hcnt;
      shift_n = shift;
      bit_cnt_n = bit_cnt;
      pix_cnt_n = pix_cnt;
      pix_data_n = PIX_DATA;
      pix_index_n = PIX_INDEX;
      pix_valid_n = 1'b0;
      frame_end_n = 1'b0;
      err_n = 1'b0;
      case (state)
         SYNC: begin
            lcnt_n = d1 ? '0 : lcnt + LW'(1);
            if (!d1 && lcnt == LW'(RESET_CYC - 1)) state_n = LOW;
         end
         LOW: begin
            if (rise) begin
               state_n = HIGH;
               hcnt_n = HW'(1);
            end else if (!d1 && lcnt != LW'(RESET_CYC)) begin
               lcnt_n = lcnt + LW'(1);
               if (lcnt == LW'(RESET_CYC - 1) && (bit_cnt != 5'd0 || pix_cnt != 16'd0)) begin
                  frame_end_n = 1'b1;
                  err_n = bit_cnt != 5'd0;
                  bit_cnt_n = 5'd0;
                  pix_cnt_n = 16'd0;
               end
            end
         end
         HIGH: begin
            if (!fall) begin
               hcnt_n = hcnt + HW'(1);
               if (hcnt == HW'(MAX_HIGH_CYC - 1)) begin
                  err_n = 1'b1;
                  bit_cnt_n = 5'd0;
                  pix_cnt_n = 16'd0;
                  lcnt_n = '0;
                  state_n = SYNC;
               end
            end else if (hcnt < HW'(MIN_HIGH_CYC)) begin
               err_n = 1'b1;
               bit_cnt_n = 5'd0;
               pix_cnt_n = 16'd0;
               lcnt_n = '0;
               state_n = SYNC;
            end else begin
               shift_n = {shift[22:0], bit_val};
               bit_cnt_n = bit_cnt + 5'd1;
               lcnt_n = LW'(1);
               state_n = LOW;
               if (bit_cnt == 5'd23) begin
                  pix_data_n = {shift[22:0], bit_val};
                  pix_index_n = pix_cnt;
                  pix_valid_n = 1'b1;
                  pix_cnt_n = pix_cnt + {15'd0, pix_cnt != 16'hFFFF};
                  bit_cnt_n = 5'd0;
               end
            end
         end
         default: state_n = SYNC;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         {s1, din_s, d1, d2} <= 4'd0;
         state <= SYNC;
         lcnt <= '0;
         hcnt <= '0;
         shift <= 24'd0;
         bit_cnt <= 5'd0;
         pix_cnt <= 16'd0;
         PIX_DATA <= 24'd0;
         PIX_VALID <= 1'b0;
         PIX_INDEX <= 16'd0;
         FRAME_END <= 1'b0;
         ERR <= 1'b0;
      end else begin
         {s1, din_s, d1, d2} <= {DIN, s1, din_s, d1};
         state <= state_n;
         lcnt <= lcnt_n;
         hcnt <= hcnt_n;
         shift <= shift_n;
         bit_cnt <= bit_cnt_n;
         pix_cnt <= pix_cnt_n;
         PIX_DATA <= pix_data_n;
         PIX_VALID <= pix_valid_n;
         PIX_INDEX <= pix_index_n;
         FRAME_END <= frame_end_n;
         ERR <= err_n;
      end
   end
`ifdef NEOPIX_RX_FWD_EN
   logic pass, pass_n;
   // line is low when the first pixel completes, so passing d1 from then on starts cleanly at the next rise
   assign pass_n = (pass | pix_valid_n) & ~frame_end_n & ~err_n;
   always_ff @(posedge CLK) begin
      if (RST) begin
         pass <= 1'b0;
         DOUT <= 1'b0;
      end else begin
         pass <= pass_n;
         DOUT <= pass_n & d1;
      end
   end
`else
   assign DOUT = 1'b0;
`endif
endmodule

// File: tb/tb_neopix_rx.sv
// tb_neopix_rx: drives WS2812 pulse trains and checks neopix_rx against a pulse-level reference model.
module tb_neopix_rx;
   localparam int THRESH = 10, MIN_H = 2, MAX_H = 32, GAP = 800;
   logic CLK = 1'b0;
   logic RST, DIN;
   logic [23:0] PIX_DATA;
   logic PIX_VALID;
   logic [15:0] PIX_INDEX;
   logic FRAME_END, ERR, DOUT;
   typedef struct {int c; bit pv; bit fe; bit er; logic [23:0] d; logic [15:0] i;} ev_t;
   ev_t evq[$];
   int vectors = 0, miscompares = 0, cyc = 0;
   bit hist [0:131071];
   bit m_sync;
   int m_bits, m_low;
   logic [23:0] m_word;
   logic [15:0] m_pix;

   neopix_rx dut (.CLK(CLK), .RST(RST), .DIN(DIN), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
                  .PIX_INDEX(PIX_INDEX), .FRAME_END(FRAME_END), .ERR(ERR), .DOUT(DOUT));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int c, input bit pv, input bit fe, input bit er, input logic [23:0] d, input logic [15:0] i);
      ev_t e;
      e.c = c;
      e.pv = pv;
      e.fe = fe;
      e.er = er;
      e.d = d;
      e.i = i;
      evq.push_back(e);
   endtask

   task automatic model_reset();
      m_sync = 0;
      m_bits = 0;
      m_low = 0;
      m_pix = 16'd0;
      m_word = 24'd0;
   endtask

   // every effect appears 3 edges after the DIN sample that triggers it
   task automatic hi_pulse(input int h);
      int r;
      r = cyc + 1;
      if (m_sync) begin
         if (h >= MAX_H || h < MIN_H) begin
            push(h >= MAX_H ? r + MAX_H + 2 : r + h + 3, 0, 0, 1, 24'd0, 16'd0);
            m_sync = 0;
            m_bits = 0;
            m_pix = 16'd0;
         end else begin
            m_word = {m_word[22:0], h >= THRESH};
            m_bits++;
            if (m_bits == 24) begin
               push(r + h + 3, 1, 0, 0, m_word, m_pix);
               m_pix = (m_pix == 16'hFFFF) ? m_pix : m_pix + 16'd1;
               m_bits = 0;
            end
         end
      end
      DIN = 1'b1;
      repeat (h) @(negedge CLK);
      m_low = 0;
   endtask

   task automatic lo_run(input int l);
      int f;
      f = cyc + 1 - m_low;
      if (m_sync && m_low < GAP && m_low + l >= GAP && (m_bits != 0 || m_pix != 16'd0)) begin
         push(f + GAP + 2, 0, 1, m_bits != 0, 24'd0, 16'd0);
         m_bits = 0;
         m_pix = 16'd0;
      end
      if (!m_sync && m_low + l > GAP) m_sync = 1;
      m_low += l;
      DIN = 1'b0;
      repeat (l) @(negedge CLK);
   endtask

   // mode 0: nominal 6/14 and 13/7 bits, 1: random widths, 2: threshold-edge 9/10 highs
   task automatic send_word(input logic [23:0] w, input int n, input int mode);
      for (int k = 23; k > 23 - n; k--) begin
         bit b;
         int h, l;
         b = w[k];
         h = mode == 0 ? (b ? 13 : 6) : mode == 1 ? int'(b ? $urandom_range(31, THRESH) : $urandom_range(THRESH - 1, MIN_H)) : (b ? THRESH : THRESH - 1);
         l = mode == 0 ? (b ? 7 : 14) : mode == 1 ? int'($urandom_range(30, 1)) : 10;
         hi_pulse(h);
         lo_run(l);
      end
   endtask

   initial begin
      bit pass_m, epv, efe, eer, edo;
      logic [23:0] last_d;
      ev_t e;
      pass_m = 0;
      last_d = 24'd0;
      forever begin
         @(posedge CLK);
         cyc++;
         hist[cyc] = DIN;
         #1;
         epv = 0;
         efe = 0;
         eer = 0;
         if (evq.size() != 0 && evq[0].c <= cyc) begin
            e = evq.pop_front();
            epv = e.pv;
            efe = e.fe;
            eer = e.er;
         end
         if (RST) begin
            pass_m = 0;
            last_d = 24'd0;
         end else begin
            if (PIX_VALID || epv) check("pix_valid", PIX_VALID, epv);
            if (epv) begin
               check("pix_data", PIX_DATA, e.d);
               check("pix_index", PIX_INDEX, e.i);
               last_d = e.d;
            end
            if (FRAME_END || efe) check("frame_end", FRAME_END, efe);
            if (efe) check("data_hold", PIX_DATA, last_d);
            if (ERR || eer) check("err", ERR, eer);
`ifdef NEOPIX_RX_FWD_EN
            pass_m = (pass_m | epv) & ~efe & ~eer;
            edo = pass_m & (cyc > 3 ? hist[cyc - 3] : 1'b0);
`else
            edo = 0;
`endif
            if (DOUT || edo) check("dout", DOUT, edo);
         end
      end
   end

   initial begin
      DIN = 1'b0;
      RST = 1'b1;
      model_reset();
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      check("rst_pix_data", PIX_DATA, 0);
      check("rst_pix_valid", PIX_VALID, 0);
      check("rst_pix_index", PIX_INDEX, 0);
      check("rst_frame_end", FRAME_END, 0);
      check("rst_err", ERR, 0);
      check("rst_dout", DOUT, 0);
      lo_run(850);
      send_word(24'h004040, 24, 0);
      lo_run(800);
      send_word(24'hFF0000, 24, 0);
      send_word(24'h00FF00, 24, 0);
      send_word(24'h0000FF, 24, 0);
      lo_run(810);
      send_word(24'h5A5A5A, 24, 0);
      lo_run(800);
      send_word(24'hAAAAAA, 24, 2);
      lo_run(800);
      send_word(24'h111111, 24, 0);
      send_word(24'h222222, 24, 0);
      lo_run(800);
      send_word(24'hC3C3C3, 10, 0);
      hi_pulse(1);
      lo_run(5);
      send_word(24'hFFFFFF, 5, 0);
      lo_run(900);
      send_word(24'h123456, 24, 0);
      lo_run(800);
      send_word(24'h000FFF, 12, 0);
      lo_run(800);
      hi_pulse(40);
      lo_run(900);
      send_word(24'h0F0F0F, 12, 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      model_reset();
      RST = 1'b0;
      lo_run(850);
      send_word(24'h0F0F0F, 24, 0);
      lo_run(800);
      for (int f = 0; f < 10; f++) begin
         int np, sel;
         np = $urandom_range(3, 1);
         for (int p = 0; p < np; p++) send_word(24'($urandom), 24, 1);
         sel = $urandom_range(3, 0);
         if (sel == 0) send_word(24'($urandom), $urandom_range(23, 1), 1);
         if (sel == 1) begin
            hi_pulse(1);
            lo_run(20);
         end
         lo_run(m_sync ? int'($urandom_range(830, GAP)) : 900);
      end
      lo_run(20);
      check("events_pending", evq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
